// File: rtl/uart_pkg.sv
// uart_pkg
// Shared types for the UART receive path.
//   rx_state_t : receiver FSM states
//   rx_frame_t : one received frame as buffered in the FIFO {ferr, perr, data}
//   count_w()  : width of an occupancy counter able to hold 0..depth
package uart_pkg;

    // Frame data width carried by rx_frame_t; the receiver WIDTH_SIZE must match.
    localparam int RX_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    typedef struct packed {
        logic                ferr;
        logic                perr;
        logic [RX_WIDTH-1:0] data;
    } rx_frame_t;

    function automatic int count_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// Show-ahead frame FIFO: the head entry is presented combinationally from
// storage while the FIFO is non-empty.
// Ports:
//   clk, reset  : clock, asynchronous active-low reset
//   push        : write push_data (ignored when full unless popping the same cycle)
//   push_data   : frame to write
//   pop         : retire the head entry (ignored when empty)
//   head        : current head entry
//   full, empty : occupancy flags
//   count       : number of entries held
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = rx_frame_t
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  T                          push_data,
    input  logic                      pop,
    output T                          head,
    output logic                      full,
    output logic                      empty,
    output logic [count_w(DEPTH)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = count_w(DEPTH);

    T                mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    // A pop frees the slot in the same cycle, so a push into a full FIFO is
    // accepted when the head is being retired.
    assign do_push = push & (~full | pop);
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl
// UART receiver: 2-flop line synchronizer, sample-tick generator, oversampled
// start/data/parity/stop FSM, frame FIFO and valid/ready host delivery.
// Ports:
//   clk, reset   : clock, asynchronous active-low reset
//   rx_in        : raw serial line (asynchronous, idle high)
//   enable       : receiver enable; low forces the FSM idle, FIFO retained
//   baud_div     : clocks per sample tick (0 behaves as 1)
//   pf_cfg       : even parity bit present, latched at start of frame
//   out_valid    : head frame available
//   out_ready    : host accepts head frame
//   out_data     : head frame data
//   out_perr     : head frame parity error
//   out_ferr     : head frame framing error
//   overrun      : sticky, a frame was dropped on a full FIFO
//   overrun_clr  : clears overrun (a simultaneous drop wins)
//   fifo_count   : frames held
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int WIDTH_SIZE = RX_WIDTH,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           rx_in,
    input  logic                           enable,
    input  logic [15:0]                    baud_div,
    input  logic                           pf_cfg,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [WIDTH_SIZE-1:0]          out_data,
    output logic                           out_perr,
    output logic                           out_ferr,
    output logic                           overrun,
    input  logic                           overrun_clr,
    output logic [count_w(FIFO_DEPTH)-1:0] fifo_count
);

    localparam int OSW = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(WIDTH_SIZE + 1);
    localparam logic [OSW-1:0] OS_LAST = OSW'(OVERSAMPLE - 1);
    localparam logic [OSW-1:0] OS_HALF = OSW'(OVERSAMPLE / 2 - 1);
    localparam logic [BW-1:0]  BIT_LAST = BW'(WIDTH_SIZE - 1);

    logic                  rx_p0;
    logic                  rx_s;
    logic [15:0]           tick_cnt;
    logic [15:0]           div_m1;
    logic                  tick;
    rx_state_t             state;
    logic [OSW-1:0]        os_cnt;
    logic [BW-1:0]         bit_cnt;
    logic [WIDTH_SIZE-1:0] shreg;
    logic                  par_acc;
    logic                  perr_r;
    logic                  pf_l;
    logic                  armed;
    logic                  push;
    logic                  pop;
    logic                  full;
    logic                  empty;
    rx_frame_t             push_frame;
    rx_frame_t             head;

    // Line synchronizer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_p0 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            rx_p0 <= rx_in;
            rx_s  <= rx_p0;
        end
    end

    // Tick generator; >= keeps a lowered baud_div from running the counter to wrap.
    assign div_m1 = (baud_div == 16'd0) ? 16'd0 : baud_div - 16'd1;
    assign tick   = enable & (tick_cnt >= div_m1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt <= '0;
        end else if (!enable || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 16'd1;
        end
    end

    // Receive FSM, advancing on tick cycles only
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            os_cnt  <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            par_acc <= 1'b0;
            perr_r  <= 1'b0;
            pf_l    <= 1'b0;
            armed   <= 1'b0;
        end else if (!enable) begin
            state  <= IDLE;
            os_cnt <= '0;
            armed  <= 1'b0;
        end else if (tick) begin
            case (state)
                IDLE: begin
                    // Arming needs a high line first, so a held break cannot retrigger.
                    if (armed && !rx_s) begin
                        state  <= START;
                        os_cnt <= '0;
                        pf_l   <= pf_cfg;
                        armed  <= 1'b0;
                    end else if (rx_s) begin
                        armed <= 1'b1;
                    end
                end
                START: begin
                    if (os_cnt == OS_HALF) begin
                        os_cnt <= '0;
                        if (rx_s) begin
                            state <= IDLE;
                        end else begin
                            state   <= DATA;
                            bit_cnt <= '0;
                            par_acc <= 1'b0;
                            perr_r  <= 1'b0;
                        end
                    end else begin
                        os_cnt <= os_cnt + OSW'(1);
                    end
                end
                DATA: begin
                    // Counting from mid-start, the terminal count lands mid-bit.
                    if (os_cnt == OS_LAST) begin
                        os_cnt  <= '0;
                        shreg   <= (shreg >> 1) | (WIDTH_SIZE'(rx_s) << (WIDTH_SIZE - 1));
                        par_acc <= par_acc ^ rx_s;
                        bit_cnt <= bit_cnt + BW'(1);
                        if (bit_cnt == BIT_LAST) begin
                            state <= pf_l ? PARITY : STOP;
                        end
                    end else begin
                        os_cnt <= os_cnt + OSW'(1);
                    end
                end
                PARITY: begin
                    if (os_cnt == OS_LAST) begin
                        os_cnt <= '0;
                        perr_r <= par_acc ^ rx_s;
                        state  <= STOP;
                    end else begin
                        os_cnt <= os_cnt + OSW'(1);
                    end
                end
                STOP: begin
                    if (os_cnt == OS_LAST) begin
                        os_cnt <= '0;
                        state  <= IDLE;
                    end else begin
                        os_cnt <= os_cnt + OSW'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    os_cnt <= '0;
                end
            endcase
        end
    end

    // Frame push on the stop-bit mid-sample, errors included
    assign push            = (state == STOP) & tick & (os_cnt == OS_LAST);
    assign push_frame.ferr = ~rx_s;
    assign push_frame.perr = perr_r;
    assign push_frame.data = shreg;

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (rx_frame_t)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_frame),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (fifo_count)
    );

    // Host delivery
    assign out_valid = ~empty;
    assign pop       = out_valid & out_ready;
    assign out_data  = head.data;
    assign out_perr  = head.perr;
    assign out_ferr  = head.ferr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overrun <= 1'b0;
        end else if (push && full && !pop) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl
// Directed bench for uart_rx_ctrl at baud_div=1, OVERSAMPLE=16 (16 clk per bit).
// Delivered frames are collected as {ferr, perr, data} whenever the host
// handshake completes, and compared against hand-computed values.
module tb_uart_rx_ctrl;

    logic       clk;
    logic       reset;
    logic       rx_in;
    logic       enable;
    logic [15:0] baud_div;
    logic       pf_cfg;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_perr;
    logic       out_ferr;
    logic       overrun;
    logic       overrun_clr;
    logic [2:0] fifo_count;

    int passed = 0;
    int failed = 0;
    int total  = 0;
    logic [9:0] popq[$];

    uart_rx_ctrl #(
        .WIDTH_SIZE (8),
        .OVERSAMPLE (16),
        .FIFO_DEPTH (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_in       (rx_in),
        .enable      (enable),
        .baud_div    (baud_div),
        .pf_cfg      (pf_cfg),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_perr    (out_perr),
        .out_ferr    (out_ferr),
        .overrun     (overrun),
        .overrun_clr (overrun_clr),
        .fifo_count  (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frames retired by the host: the pop happens on the following posedge.
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            popq.push_back({out_ferr, out_perr, out_data});
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Idle high, start bit, 8 data bits LSB first, optional parity, stop.
    // The line is left at the stop level.
    task automatic send_frame(input logic [7:0] d, input logic par_en,
                              input logic par_bit, input logic stop_bit);
        rx_in = 1'b1;
        step(4);
        rx_in = 1'b0;
        step(16);
        for (int i = 0; i < 8; i++) begin
            rx_in = d[i];
            step(16);
        end
        if (par_en) begin
            rx_in = par_bit;
            step(16);
        end
        rx_in = stop_bit;
        step(16);
    endtask

    task automatic wait_pops(input int n);
        for (int i = 0; i < 200 && popq.size() < n; i++) begin
            step(1);
        end
    endtask

    initial begin
        reset       = 1'b0;
        rx_in       = 1'b1;
        enable      = 1'b1;
        baud_div    = 16'd1;
        pf_cfg      = 1'b0;
        out_ready   = 1'b0;
        overrun_clr = 1'b0;
        step(3);

        // Reset state
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_flags", {out_perr, out_ferr, overrun}, 0);
        chk("rst_count", fifo_count, 0);
        reset = 1'b1;
        step(4);

        // 1: plain 0xA5, no parity
        out_ready = 1'b1;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
        wait_pops(1);
        step(2);
        chk("t1_pops", popq.size(), 1);
        chk("t1_frame", popq[0], 10'h0A5);
        chk("t1_count", fifo_count, 0);
        chk("t1_valid", out_valid, 0);

        // 2: even parity, wrong then right parity bit
        pf_cfg = 1'b1;
        send_frame(8'hA5, 1'b1, 1'b1, 1'b1);
        wait_pops(2);
        chk("t2_bad_par", popq[1], 10'h1A5);
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
        wait_pops(3);
        chk("t2_good_par", popq[2], 10'h0A5);
        pf_cfg = 1'b0;

        // 3: framing error followed by a held break
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        step(40);
        rx_in = 1'b1;
        step(250);
        chk("t3_pops", popq.size(), 4);
        chk("t3_frame", popq[3], 10'h23C);

        // 4: short low glitch is a false start
        out_ready = 1'b0;
        rx_in = 1'b0;
        step(5);
        rx_in = 1'b1;
        step(200);
        chk("t4_valid", out_valid, 0);
        chk("t4_count", fifo_count, 0);

        // 5: five frames into a 4-deep FIFO with no host
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 1'b0, 1'b0, 1'b1);
        end
        step(10);
        chk("t5_count", fifo_count, 4);
        chk("t5_overrun", overrun, 1);
        chk("t5_head", out_data, 8'h01);
        out_ready = 1'b1;
        wait_pops(8);
        step(2);
        out_ready = 1'b0;
        chk("t5_pops", popq.size(), 8);
        chk("t5_pop1", popq[4], 10'h001);
        chk("t5_pop2", popq[5], 10'h002);
        chk("t5_pop3", popq[6], 10'h003);
        chk("t5_pop4", popq[7], 10'h004);
        chk("t5_empty", fifo_count, 0);
        chk("t5_ovr_held", overrun, 1);
        overrun_clr = 1'b1;
        step(1);
        overrun_clr = 1'b0;
        chk("t5_ovr_clr", overrun, 0);

        // 6a: reset in the middle of 0x55 with a frame already buffered
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
        step(4);
        chk("t6_pre_count", fifo_count, 1);
        rx_in = 1'b1;
        step(4);
        rx_in = 1'b0;
        step(16);
        rx_in = 1'b1;
        step(16);
        rx_in = 1'b0;
        step(16);
        rx_in = 1'b1;
        step(8);
        reset = 1'b0;
        #1;
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_data", out_data, 0);
        chk("t6_rst_count", fifo_count, 0);
        step(3);
        reset = 1'b1;
        step(200);
        chk("t6_no_frame", out_valid, 0);
        out_ready = 1'b1;
        send_frame(8'h66, 1'b0, 1'b0, 1'b1);
        wait_pops(9);
        step(2);
        chk("t6_pops", popq.size(), 9);
        chk("t6_frame", popq[8], 10'h066);

        // 6b: enable dropped mid-frame keeps the FIFO and idles the FSM
        out_ready = 1'b0;
        send_frame(8'h77, 1'b0, 1'b0, 1'b1);
        step(4);
        rx_in = 1'b1;
        step(4);
        rx_in = 1'b0;
        step(16);
        rx_in = 1'b1;
        step(16);
        rx_in = 1'b0;
        step(8);
        enable = 1'b0;
        step(4);
        rx_in = 1'b1;
        step(20);
        chk("t6_en_count", fifo_count, 1);
        chk("t6_en_head", out_data, 8'h77);
        chk("t6_en_valid", out_valid, 1);
        enable = 1'b1;
        step(300);
        chk("t6_en_idle", fifo_count, 1);
        out_ready = 1'b1;
        wait_pops(10);
        step(2);
        chk("t6_en_frame", popq[9], 10'h077);
        chk("t6_en_pops", popq.size(), 10);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
